// File: rtl/adc_pkg.sv
// Shared constants and elaboration-time width/scale helpers for the ADC
// capture and millivolt conversion path.
package adc_pkg;

   // Fixed-point fraction bits of the mV scale factor
   localparam int unsigned MV_SHIFT = 13;

   // mV per code step, scaled by 2^MV_SHIFT
   function automatic int unsigned calc_scale(input int unsigned fs_mv,
                                              input int unsigned adc_w);
      longint unsigned s;
      s = {32'd0, fs_mv} << MV_SHIFT;
      s = s >> adc_w;
      return 32'(s);
   endfunction

   // Accumulator holds 2^avg_log2 full-scale codes without overflow
   function automatic int unsigned acc_width(input int unsigned adc_w,
                                             input int unsigned avg_log2);
      return adc_w + avg_log2;
   endfunction

   function automatic int unsigned prod_width(input int unsigned adc_w,
                                              input int unsigned scale);
      return adc_w + $clog2(scale + 1);
   endfunction

   // Offset-binary zero point
   function automatic int unsigned mid_code(input int unsigned adc_w);
      return 32'd1 << (adc_w - 1);
   endfunction

endpackage

// File: rtl/adc_ch_conv.sv
// One ADC channel: window accumulator, sign/magnitude, scale multiply and
// saturating signed-mV output register. Window control comes from the top.
module adc_ch_conv
   import adc_pkg::*;
#(
   parameter int unsigned ADC_W    = 12,
   parameter int unsigned FS_MV    = 10000,
   parameter int unsigned AVG_LOG2 = 2,
   parameter int unsigned OUT_W    = 16
) (
   input  logic             ad_clk,
   input  logic             sys_rst_n,
   input  logic [ADC_W-1:0] code,
   input  logic             smp,
   input  logic             clr,
   input  logic             last,
   input  logic             out_en,
   output logic [OUT_W-1:0] volt_mv,
   output logic             ovr
);

   localparam int unsigned ACC_W  = acc_width(ADC_W, AVG_LOG2);
   localparam int unsigned SCALE  = calc_scale(FS_MV, ADC_W);
   localparam int unsigned PROD_W = prod_width(ADC_W, SCALE);
   localparam int unsigned S_W    = (PROD_W + 1 > OUT_W) ? PROD_W + 1 : OUT_W;

   localparam logic [ADC_W-1:0]         MID     = ADC_W'(mid_code(ADC_W));
   localparam logic [PROD_W-1:0]        SCALE_C = PROD_W'(SCALE);
   localparam logic signed [S_W-1:0]    VMAX    = S_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
   localparam logic signed [S_W-1:0]    VMIN    = S_W'(-(64'sd1 <<< (OUT_W - 1)));

   logic [ACC_W-1:0]  acc;
   logic [ACC_W-1:0]  acc_sum;
   logic              code_ovr;
   logic              ovr_acc;
   logic [ADC_W-1:0]  avg;
   logic              avg_ovr;
   logic              sgn2;
   logic [ADC_W-1:0]  mag2;
   logic              ovr2;
   logic              sgn3;
   logic [PROD_W-1:0] prod3;
   logic              ovr3;
   logic signed [S_W-1:0] mx;
   logic signed [S_W-1:0] sval;
   logic signed [S_W-1:0] sclip;

   assign acc_sum  = acc + ACC_W'(code);
   assign code_ovr = (code == '0) || (code == '1);

   // Window accumulator; a clear discards the sample presented with it
   always_ff @(posedge ad_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         acc     <= '0;
         ovr_acc <= 1'b0;
         avg     <= '0;
         avg_ovr <= 1'b0;
      end else if (clr) begin
         acc     <= '0;
         ovr_acc <= 1'b0;
      end else if (smp) begin
         if (last) begin
            avg     <= ADC_W'(acc_sum >> AVG_LOG2);
            avg_ovr <= ovr_acc | code_ovr;
            acc     <= '0;
            ovr_acc <= 1'b0;
         end else begin
            acc     <= acc_sum;
            ovr_acc <= ovr_acc | code_ovr;
         end
      end
   end

   // Sign/magnitude and multiply stages run freely; avg only moves per window
   always_ff @(posedge ad_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         sgn2  <= 1'b0;
         mag2  <= '0;
         ovr2  <= 1'b0;
         sgn3  <= 1'b0;
         prod3 <= '0;
         ovr3  <= 1'b0;
      end else begin
         sgn2  <= (avg < MID);
         mag2  <= (avg >= MID) ? (avg - MID) : (MID - avg);
         ovr2  <= avg_ovr;
         sgn3  <= sgn2;
         prod3 <= PROD_W'(mag2) * SCALE_C;
         ovr3  <= ovr2;
      end
   end

   // Truncate magnitude toward zero, apply sign, clip to the output range
   always_comb begin
      mx    = S_W'(prod3 >> MV_SHIFT);
      sval  = sgn3 ? -mx : mx;
      sclip = sval;
      if (sval > VMAX) begin
         sclip = VMAX;
      end else if (sval < VMIN) begin
         sclip = VMIN;
      end
   end

   // Output holds between strobes
   always_ff @(posedge ad_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         volt_mv <= '0;
         ovr     <= 1'b0;
      end else if (out_en) begin
         volt_mv <= OUT_W'(sclip);
         ovr     <= ovr3;
      end
   end

endmodule

// File: rtl/adc_multi_ch_volt_avg.sv
// Multi-channel ADC capture with box-car averaging and signed mV output.
// Capture, the shared window counter and valid pipeline live here; per-channel
// arithmetic lives in adc_ch_conv.
module adc_multi_ch_volt_avg
   import adc_pkg::*;
#(
   parameter int unsigned CH_NUM   = 2,
   parameter int unsigned ADC_W    = 12,
   parameter int unsigned BIT_REV  = 1,
   parameter int unsigned FS_MV    = 10000,
   parameter int unsigned AVG_LOG2 = 2,
   parameter int unsigned OUT_W    = 16
) (
   input  logic                    ad_clk,
   input  logic                    sys_rst_n,
   input  logic                    smp_en,
   input  logic                    win_clr,
   input  logic [CH_NUM*ADC_W-1:0] ad_in,
   output logic [CH_NUM*OUT_W-1:0] volt_mv,
   output logic [CH_NUM-1:0]       ovr,
   output logic                    volt_vld
);

   localparam int unsigned      CNT_W    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((2 ** AVG_LOG2) - 1);

   logic [CH_NUM*ADC_W-1:0] cap_d;
   logic [CH_NUM*ADC_W-1:0] cap_code;
   logic                    s0_vld;
   logic [CNT_W-1:0]        cnt;
   logic                    win_last;
   logic                    avg_vld;
   logic                    s2_vld;
   logic                    s3_vld;

   // Optional per-channel bit reversal of the raw pins
   always_comb begin
      cap_d = ad_in;
      if (BIT_REV != 0) begin
         for (int ch = 0; ch < CH_NUM; ch++) begin
            for (int b = 0; b < ADC_W; b++) begin
               cap_d[ch*ADC_W + b] = ad_in[ch*ADC_W + ADC_W - 1 - b];
            end
         end
      end
   end

   // Capture register, with the sample qualifier aligned to the code
   always_ff @(posedge ad_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cap_code <= '0;
         s0_vld   <= 1'b0;
      end else begin
         cap_code <= cap_d;
         s0_vld   <= smp_en;
      end
   end

   assign win_last = s0_vld && !win_clr && (cnt == CNT_LAST);

   // Shared window sample counter
   always_ff @(posedge ad_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cnt <= '0;
      end else if (win_clr) begin
         cnt <= '0;
      end else if (s0_vld) begin
         cnt <= win_last ? '0 : cnt + 1'b1;
      end
   end

   // Valid pipeline tracking the per-channel arithmetic stages
   always_ff @(posedge ad_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         avg_vld  <= 1'b0;
         s2_vld   <= 1'b0;
         s3_vld   <= 1'b0;
         volt_vld <= 1'b0;
      end else begin
         avg_vld  <= win_last;
         s2_vld   <= avg_vld;
         s3_vld   <= s2_vld;
         volt_vld <= s3_vld;
      end
   end

   for (genvar ch = 0; ch < CH_NUM; ch++) begin : g_ch
      adc_ch_conv #(
         .ADC_W    (ADC_W),
         .FS_MV    (FS_MV),
         .AVG_LOG2 (AVG_LOG2),
         .OUT_W    (OUT_W)
      ) u_ch_conv (
         .ad_clk    (ad_clk),
         .sys_rst_n (sys_rst_n),
         .code      (cap_code[ch*ADC_W +: ADC_W]),
         .smp       (s0_vld),
         .clr       (win_clr),
         .last      (win_last),
         .out_en    (s3_vld),
         .volt_mv   (volt_mv[ch*OUT_W +: OUT_W]),
         .ovr       (ovr[ch])
      );
   end

endmodule

// File: tb/tb_adc_multi_ch_volt_avg.sv
// Directed scoreboard bench for adc_multi_ch_volt_avg at default parameters.
module tb_adc_multi_ch_volt_avg;

   logic        ad_clk = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic        smp_en = 1'b0;
   logic        win_clr = 1'b0;
   logic [23:0] ad_in = '0;
   logic [31:0] volt_mv;
   logic [1:0]  ovr;
   logic        volt_vld;

   typedef struct {
      int         v0;
      int         v1;
      logic [1:0] o;
      int         cyc;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   hold0 = 0;
   int   hold1 = 0;
   logic [1:0] hold_o = 2'b00;

   adc_multi_ch_volt_avg u_dut (
      .ad_clk    (ad_clk),
      .sys_rst_n (sys_rst_n),
      .smp_en    (smp_en),
      .win_clr   (win_clr),
      .ad_in     (ad_in),
      .volt_mv   (volt_mv),
      .ovr       (ovr),
      .volt_vld  (volt_vld)
   );

   always #5 ad_clk = ~ad_clk;

   always @(posedge ad_clk) cyc <= cyc + 1;

   function automatic logic [11:0] rev12(input logic [11:0] c);
      logic [11:0] r;
      for (int b = 0; b < 12; b++) r[b] = c[11-b];
      return r;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Drive one cycle of stimulus; captured at the next rising edge
   task automatic drive(input logic [11:0] c0, input logic [11:0] c1,
                        input logic en, input logic clr);
      @(posedge ad_clk);
      #1;
      ad_in   = {rev12(c1), rev12(c0)};
      smp_en  = en;
      win_clr = clr;
   endtask

   // Call right after driving a window's last sample
   task automatic expect_res(input int v0, input int v1, input logic [1:0] o);
      exp_t e;
      e.v0 = v0;
      e.v1 = v1;
      e.o = o;
      e.cyc = cyc + 5;
      q.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(12'($urandom), 12'($urandom), 1'b0, 1'b0);
   endtask

   task automatic win4(input logic [11:0] c0, input logic [11:0] c1,
                       input int v0, input int v1, input logic [1:0] o);
      for (int i = 0; i < 4; i++) drive(c0, c1, 1'b1, 1'b0);
      expect_res(v0, v1, o);
   endtask

   // Monitor: reset state, strobe contents and timing, hold between strobes
   always @(negedge ad_clk) begin
      exp_t e;
      if (!sys_rst_n) begin
         chk("rst_volt_mv", int'(volt_mv), 0);
         chk("rst_ovr", int'(ovr), 0);
         chk("rst_volt_vld", int'(volt_vld), 0);
         hold0 = 0;
         hold1 = 0;
         hold_o = 2'b00;
      end else if (volt_vld) begin
         if (q.size() == 0) begin
            chk("spurious_vld", 1, 0);
         end else begin
            e = q.pop_front();
            chk("vld_cycle", cyc, e.cyc);
            chk("ch0_mv", int'($signed(volt_mv[15:0])), e.v0);
            chk("ch1_mv", int'($signed(volt_mv[31:16])), e.v1);
            chk("ovr", int'(ovr), int'(e.o));
            hold0 = e.v0;
            hold1 = e.v1;
            hold_o = e.o;
         end
      end else begin
         chk("hold_ch0", int'($signed(volt_mv[15:0])), hold0);
         chk("hold_ch1", int'($signed(volt_mv[31:16])), hold1);
         chk("hold_ovr", int'(ovr), int'(hold_o));
         if (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            chk("missing_vld", 0, 1);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset with random pins and smp_en high
      for (int i = 0; i < 5; i++) begin
         @(posedge ad_clk);
         #1;
         ad_in  = 24'($urandom);
         smp_en = 1'b1;
      end
      @(posedge ad_clk);
      #1;
      sys_rst_n = 1'b1;
      smp_en = 1'b0;
      idle(2);

      // Midscale, then continuous back-to-back windows
      win4(12'h800, 12'h800, 0, 0, 2'b00);
      win4(12'h800, 12'h801, 0, 2, 2'b00);
      win4(12'h800, 12'h7FF, 0, -2, 2'b00);
      idle(6);

      // Extremes and a single over-range sample inside a window
      win4(12'hFFF, 12'h000, 4997, -5000, 2'b11);
      drive(12'h800, 12'h7FF, 1'b1, 1'b0);
      drive(12'hFFF, 12'h7FF, 1'b1, 1'b0);
      drive(12'h800, 12'h7FF, 1'b1, 1'b0);
      drive(12'h800, 12'h7FF, 1'b1, 1'b0);
      expect_res(1247, -2, 2'b01);
      idle(6);

      // Averaging with floor
      drive(12'hC00, 12'h400, 1'b1, 1'b0);
      drive(12'hC00, 12'h400, 1'b1, 1'b0);
      drive(12'hC01, 12'h400, 1'b1, 1'b0);
      drive(12'hC02, 12'h400, 1'b1, 1'b0);
      expect_res(2500, -2500, 2'b00);
      idle(6);

      // Gap in the middle of a window; junk codes while smp_en is low
      drive(12'h900, 12'h700, 1'b1, 1'b0);
      drive(12'h900, 12'h700, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) drive(12'hFFF, 12'h000, 1'b0, 1'b0);
      drive(12'h900, 12'h700, 1'b1, 1'b0);
      drive(12'h900, 12'h700, 1'b1, 1'b0);
      expect_res(625, -625, 2'b00);
      idle(6);

      // Clear after two over-range samples: needs four more, ovr cleared
      drive(12'hFFF, 12'h000, 1'b1, 1'b0);
      drive(12'hFFF, 12'h000, 1'b1, 1'b0);
      drive(12'h800, 12'h800, 1'b0, 1'b1);
      drive(12'h800, 12'h800, 1'b0, 1'b0);
      win4(12'hA00, 12'h600, 1250, -1250, 2'b00);
      idle(6);

      // Reset mid-window: partial window is dropped
      for (int i = 0; i < 3; i++) drive(12'h000, 12'hFFF, 1'b1, 1'b0);
      @(posedge ad_clk);
      #1;
      sys_rst_n = 1'b0;
      smp_en = 1'b0;
      idle(3);
      @(posedge ad_clk);
      #1;
      sys_rst_n = 1'b1;
      idle(2);
      drive(12'hB00, 12'h500, 1'b1, 1'b0);
      idle(2);
      drive(12'hB00, 12'h500, 1'b1, 1'b0);
      drive(12'hB00, 12'h500, 1'b1, 1'b0);
      drive(12'hB00, 12'h500, 1'b1, 1'b0);
      expect_res(1875, -1875, 2'b00);
      idle(10);

      chk("queue_empty", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
